// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the program-counter sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    localparam int unsigned PC_WIDTH_DEF     = 32;
    localparam int unsigned PC_INC_DEF       = 4;
    localparam int unsigned PC_RESET_VEC_DEF = 0;
    localparam int unsigned PC_RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack: a push onto a full stack overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic [WIDTH-1:0] mem_q [RAS_DEPTH];

    // sp points at the next free slot; wrapping it is what discards the oldest entry.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push) begin
            sp_d = sp_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop && (cnt_q != '0)) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
        empty_d = (cnt_d == '0);
        full_d  = (cnt_d == CNT_W'(RAS_DEPTH));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q    <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
            full_q  <= full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[sp_q] <= push_data;
        end
    end

    assign top   = mem_q[sp_q - PTR_W'(1)];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with BOOT/RUN/HALT control.
// Return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned INC       = PC_INC_DEF,
    parameter int unsigned RESET_VEC = PC_RESET_VEC_DEF,
    parameter int unsigned RAS_DEPTH = PC_RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             branch,
    input  logic [WIDTH-1:0] branch_tgt,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_next_seq,
    output logic             pc_valid,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VEC);
    localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;

    assign pc          = pc_q;
    assign pc_next_seq = pc_q + INC_W;
    assign pc_valid    = (state_q == ST_RUN);

`ifdef PC_SEQ_RAS_EN
    logic             ras_push, ras_pop;
    logic             ret_miss_q, ret_miss_d;
    logic [WIDTH-1:0] ras_top;

    pc_ras #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .reset     (reset),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_next_seq),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign ret_miss = ret_miss_q;
`else
    logic call_unused;

    assign call_unused = call;
    assign ras_empty   = 1'b1;
    assign ras_full    = 1'b0;
    assign ret_miss    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_SEQ_RAS_EN
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ret_miss_d = 1'b0;
`endif
        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_d = ST_HALT;
                end else if (branch) begin
                    pc_d = branch_tgt;
`ifdef PC_SEQ_RAS_EN
                    ras_push = call;
`endif
                end else if (ret) begin
`ifdef PC_SEQ_RAS_EN
                    if (!ras_empty) begin
                        pc_d    = ras_top;
                        ras_pop = 1'b1;
                    end else begin
                        pc_d       = pc_next_seq;
                        ret_miss_d = 1'b1;
                    end
`else
                    pc_d = pc_next_seq;
`endif
                end else if (!stall) begin
                    pc_d = pc_next_seq;
                end
            end
            ST_HALT: begin
                if (resume && !halt) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_BOOT;
            pc_q    <= RST_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_SEQ_RAS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ret_miss_q <= 1'b0;
        end else begin
            ret_miss_q <= ret_miss_d;
        end
    end
`endif

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq against a queue-based reference model.
module tb_pc_seq;

    localparam int unsigned W     = 32;
    localparam int unsigned RAS_D = 4;
`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, stall, halt, resume, branch, call, ret;
    logic [W-1:0]  branch_tgt;
    logic [W-1:0]  pc, pc_next_seq;
    logic          pc_valid, ras_empty, ras_full, ret_miss;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=boot 1=run 2=halt, stack as a queue (back = top).
    int           m_mode;
    logic [W-1:0] m_pc;
    logic [W-1:0] m_stk[$];
    logic         m_miss;

    pc_seq #(.WIDTH(W), .INC(4), .RESET_VEC(0), .RAS_DEPTH(RAS_D)) dut (
        .clk(clk), .reset(reset), .stall(stall), .halt(halt), .resume(resume),
        .branch(branch), .branch_tgt(branch_tgt), .call(call), .ret(ret),
        .pc(pc), .pc_next_seq(pc_next_seq), .pc_valid(pc_valid),
        .ras_empty(ras_empty), .ras_full(ras_full), .ret_miss(ret_miss)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 0;
        m_pc   = '0;
        m_stk.delete();
        m_miss = 1'b0;
    endtask

    task automatic model_edge();
        m_miss = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (resume && !halt) m_mode = 1;
        end else if (halt) begin
            m_mode = 2;
        end else if (branch) begin
            if (RAS_EN && call) begin
                m_stk.push_back(m_pc + 4);
                if (m_stk.size() > RAS_D) m_stk.delete(0);
            end
            m_pc = branch_tgt;
        end else if (ret) begin
            if (RAS_EN && m_stk.size() > 0) begin
                m_pc = m_stk.pop_back();
            end else begin
                m_pc   = m_pc + 4;
                m_miss = RAS_EN;
            end
        end else if (!stall) begin
            m_pc = m_pc + 4;
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] e_next;
        logic         e_empty, e_full;
        e_next  = m_pc + 4;
        e_empty = (m_stk.size() == 0);
        e_full  = (m_stk.size() == RAS_D);
        checks++;
        assert (pc === m_pc) else begin
            errors++; $error("FAIL %s pc got %h exp %h", tag, pc, m_pc);
        end
        checks++;
        assert (pc_valid === (m_mode == 1)) else begin
            errors++; $error("FAIL %s pc_valid got %b exp %b", tag, pc_valid, (m_mode == 1));
        end
        checks++;
        assert (pc_next_seq === e_next) else begin
            errors++; $error("FAIL %s pc_next_seq got %h exp %h", tag, pc_next_seq, e_next);
        end
        checks++;
        assert (ras_empty === e_empty) else begin
            errors++; $error("FAIL %s ras_empty got %b exp %b", tag, ras_empty, e_empty);
        end
        checks++;
        assert (ras_full === e_full) else begin
            errors++; $error("FAIL %s ras_full got %b exp %b", tag, ras_full, e_full);
        end
        checks++;
        assert (ret_miss === m_miss) else begin
            errors++; $error("FAIL %s ret_miss got %b exp %b", tag, ret_miss, m_miss);
        end
    endtask

    task automatic step(input string tag, input logic h, input logic rs, input logic b,
                        input logic c, input logic rt, input logic s, input logic [W-1:0] t);
        halt = h; resume = rs; branch = b; call = c; ret = rt; stall = s; branch_tgt = t;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        {stall, halt, resume, branch, call, ret} = '0;
        branch_tgt = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;
        #1;
        check_all("boot");

        // BOOT->RUN at pc 0, then 4, 8, C
        for (int i = 0; i < 4; i++) step("seq", 0, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 20 && m_pc != 32'h20; i++) step("seq20", 0, 0, 0, 0, 0, 0, '0);

        step("call100", 0, 0, 1, 1, 0, 0, 32'h100);
        step("ret24", 0, 0, 0, 0, 1, 0, '0);

        // five nested calls overflow a four-deep stack, then five returns
        for (int i = 0; i < 5; i++) step("call5", 0, 0, 1, 1, 0, 0, 32'h1000 + 32'(i) * 32'h100);
        for (int i = 0; i < 5; i++) step("ret5", 0, 0, 0, 0, 1, 0, '0);
        step("after_miss", 0, 0, 0, 0, 0, 0, '0);

        step("stall_br", 0, 0, 1, 0, 0, 1, 32'h400);
        for (int i = 0; i < 3; i++) step("stall", 0, 0, 0, 0, 0, 1, '0);
        step("halt", 1, 0, 0, 0, 0, 0, '0);
        step("halt_br", 0, 0, 1, 1, 1, 0, 32'h800);
        step("halt_res_hold", 1, 1, 0, 0, 0, 0, '0);
        step("resume", 0, 1, 0, 0, 0, 0, '0);
        step("run_again", 0, 0, 0, 0, 0, 0, '0);

        step("br_top", 0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC);
        step("wrap", 0, 0, 0, 0, 0, 0, '0);

        // asynchronous reset while halted with a non-empty stack
        step("pre_call", 0, 0, 1, 1, 0, 0, 32'h200);
        step("pre_halt", 1, 0, 0, 0, 0, 0, '0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        reset = 1'b0;
        step("post_rst_boot", 0, 0, 0, 0, 0, 0, '0);

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] t;
            t = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & ~32'h3);
            step("rand", ($urandom % 16) == 0, ($urandom % 3) == 0, ($urandom % 5) == 0,
                 1'($urandom % 2), ($urandom % 4) == 0, ($urandom % 4) == 0, t);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
